// File: rtl/az_sample_capture_pkg.sv
// Shared definitions for the auto-zero sample capture block: state encoding,
// default clock frequency, monitor bit map and the signed difference helper.
package az_sample_capture_pkg;

    localparam int unsigned DEF_CLK_FREQ = 32'd20000000;
    localparam int unsigned DATA_W       = 32'd24;
    localparam int unsigned DIFF_W       = 32'd25;
    localparam int unsigned COUNT_W      = 32'd32;

    localparam int unsigned MON_STATE_LSB        = 32'd0;
    localparam int unsigned MON_ADC_START_BIT    = 32'd3;
    localparam int unsigned MON_RESULT_VALID_BIT = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_ADC = 3'd3,
        ST_STORE    = 3'd4,
        ST_PAIR     = 3'd5
    } state_e;

    // Both operands are sign-extended by one bit, so the difference cannot overflow.
    function automatic logic [DIFF_W-1:0] diff_ext(input logic [DATA_W-1:0] hi,
                                                  input logic [DATA_W-1:0] lo);
        return {hi[DATA_W-1], hi} - {lo[DATA_W-1], lo};
    endfunction

endpackage

// File: rtl/az_sample_capture_if.sv
// ADC request/response handshake and result valid/ready channel of the capture block.
interface az_sample_capture_if;
    import az_sample_capture_pkg::*;

    logic              adc_start;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic [DATA_W-1:0] result_hi;
    logic [DATA_W-1:0] result_lo;
    logic [DIFF_W-1:0] result_diff;
    logic              result_valid;
    logic              result_ready;

    modport master (
        output adc_start,
        input  adc_valid,
        input  adc_data,
        output result_hi,
        output result_lo,
        output result_diff,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  adc_start,
        output adc_valid,
        output adc_data,
        input  result_hi,
        input  result_lo,
        input  result_diff,
        input  result_valid,
        output result_ready
    );

endinterface

// File: rtl/az_sample_capture_down_counter.sv
// Loadable down-counter; last flags the final counted cycle (value 1, or an empty load of 0).
module down_counter #(
    parameter int unsigned WIDTH = 32'd24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load takes priority, decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {WIDTH{1'b0}})) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q <= WIDTH'(1));

endmodule

// File: rtl/az_sample_capture.sv
// Captures HI/LO ADC conversions per modulation window and emits their signed
// difference on a valid/ready channel, with sticky overrun/timeout/short-window flags.
module az_sample_capture
    import az_sample_capture_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
    parameter int unsigned TIMEOUT_N = CLK_FREQ / 32'd1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_active,
    input  logic                  sample_phase,
    input  logic [DATA_W-1:0]     settle_n,
    az_sample_capture_if.master   bus,
    output logic [COUNT_W-1:0]    sample_count,
    input  logic                  err_clr,
    output logic                  err_overrun,
    output logic                  err_timeout,
    output logic                  err_short,
    output logic [7:0]            monitor
);

    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_N);

    state_e               state_q, state_d;
    logic                 act_dly_q, act_dly_d;
    logic                 phase_q, phase_d;
    logic [DATA_W-1:0]    hold_hi_q, hold_hi_d, hold_lo_q, hold_lo_d;
    logic                 have_hi_q, have_hi_d, have_lo_q, have_lo_d;
    logic                 adc_start_q, adc_start_d;
    logic [DATA_W-1:0]    result_hi_q, result_hi_d, result_lo_q, result_lo_d;
    logic [DIFF_W-1:0]    result_diff_q, result_diff_d;
    logic                 result_valid_q, result_valid_d;
    logic [COUNT_W-1:0]   sample_count_q, sample_count_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 err_short_q, err_short_d;
    logic [7:0]           monitor_s;

    logic win_start_s, settle_load_s, settle_dec_s, settle_last_s;
    logic to_load_s, to_dec_s, to_last_s;
    logic store_s, pair_s, overrun_s, handshake_s, short_set_s, timeout_set_s;

    assign win_start_s   = sample_active & ~act_dly_q;
    assign settle_load_s = (state_q == ST_IDLE) & win_start_s;
    assign settle_dec_s  = (state_q == ST_SETTLE);
    assign to_load_s     = (state_q == ST_START);
    assign to_dec_s      = (state_q == ST_WAIT_ADC);
    assign store_s       = to_dec_s & bus.adc_valid;
    assign timeout_set_s = to_dec_s & ~bus.adc_valid & to_last_s;
    assign short_set_s   = ((state_q == ST_SETTLE) | (state_q == ST_START)) & ~sample_active;
    assign handshake_s   = result_valid_q & bus.result_ready;
    assign pair_s        = (state_q == ST_PAIR);
    assign overrun_s     = pair_s & result_valid_q & ~bus.result_ready;

    down_counter #(.WIDTH(DATA_W)) u_settle_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (settle_load_s),
        .load_val (settle_n),
        .dec      (settle_dec_s),
        .last     (settle_last_s)
    );

    down_counter #(.WIDTH(32'd32)) u_timeout_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (to_load_s),
        .load_val (TIMEOUT_LOAD),
        .dec      (to_dec_s),
        .last     (to_last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero settle time skips SETTLE so START follows detection directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_start_s) begin
                    if (settle_n == 24'd0) state_d = ST_START;
                    else                   state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!sample_active)     state_d = ST_IDLE;
                else if (settle_last_s) state_d = ST_START;
                else                    state_d = ST_SETTLE;
            end
            ST_START: begin
                if (!sample_active) state_d = ST_IDLE;
                else                state_d = ST_WAIT_ADC;
            end
            ST_WAIT_ADC: begin
                if (bus.adc_valid)  state_d = ST_STORE;
                else if (to_last_s) state_d = ST_IDLE;
                else                state_d = ST_WAIT_ADC;
            end
            ST_STORE: begin
                if (!phase_q && have_hi_q) state_d = ST_PAIR;
                else                       state_d = ST_IDLE;
            end
            ST_PAIR: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath, handshake and error flag next values.
    always_comb begin
        act_dly_d      = sample_active;
        phase_d        = phase_q;
        hold_hi_d      = hold_hi_q;
        hold_lo_d      = hold_lo_q;
        have_hi_d      = have_hi_q;
        have_lo_d      = have_lo_q;
        result_hi_d    = result_hi_q;
        result_lo_d    = result_lo_q;
        result_diff_d  = result_diff_q;
        result_valid_d = result_valid_q;
        adc_start_d    = (state_d == ST_START);

        if (settle_load_s) phase_d = sample_phase;
        else               phase_d = phase_q;

        if (store_s) begin
            if (phase_q) begin
                hold_hi_d = bus.adc_data;
                have_hi_d = 1'b1;
            end else begin
                hold_lo_d = bus.adc_data;
                have_lo_d = 1'b1;
            end
        end else if (pair_s) begin
            have_hi_d = 1'b0;
            have_lo_d = 1'b0;
        end else begin
            have_hi_d = have_hi_q;
            have_lo_d = have_lo_q;
        end

        // A pair arriving while the previous result is still unaccepted is dropped.
        if (pair_s && !overrun_s) begin
            result_hi_d    = hold_hi_q;
            result_lo_d    = hold_lo_q;
            result_diff_d  = diff_ext(hold_hi_q, hold_lo_q);
            result_valid_d = 1'b1;
        end else if (handshake_s) begin
            result_valid_d = 1'b0;
        end else begin
            result_valid_d = result_valid_q;
        end

        if (handshake_s) sample_count_d = sample_count_q + 32'd1;
        else             sample_count_d = sample_count_q;

        err_overrun_d = overrun_s     | (err_overrun_q & ~err_clr);
        err_timeout_d = timeout_set_s | (err_timeout_q & ~err_clr);
        err_short_d   = short_set_s   | (err_short_q   & ~err_clr);
    end

    // Datapath registers; the delayed window copy resets high so a window in progress is not a start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_dly_q      <= 1'b1;
            phase_q        <= 1'b0;
            hold_hi_q      <= 24'd0;
            hold_lo_q      <= 24'd0;
            have_hi_q      <= 1'b0;
            have_lo_q      <= 1'b0;
            adc_start_q    <= 1'b0;
            result_hi_q    <= 24'd0;
            result_lo_q    <= 24'd0;
            result_diff_q  <= 25'd0;
            result_valid_q <= 1'b0;
            sample_count_q <= 32'd0;
            err_overrun_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_short_q    <= 1'b0;
        end else begin
            act_dly_q      <= act_dly_d;
            phase_q        <= phase_d;
            hold_hi_q      <= hold_hi_d;
            hold_lo_q      <= hold_lo_d;
            have_hi_q      <= have_hi_d;
            have_lo_q      <= have_lo_d;
            adc_start_q    <= adc_start_d;
            result_hi_q    <= result_hi_d;
            result_lo_q    <= result_lo_d;
            result_diff_q  <= result_diff_d;
            result_valid_q <= result_valid_d;
            sample_count_q <= sample_count_d;
            err_overrun_q  <= err_overrun_d;
            err_timeout_q  <= err_timeout_d;
            err_short_q    <= err_short_d;
        end
    end

    // Debug monitor assembled from registered state only.
    always_comb begin
        monitor_s = 8'h00;
        monitor_s[MON_STATE_LSB +: 3]      = state_q;
        monitor_s[MON_ADC_START_BIT]       = adc_start_q;
        monitor_s[MON_RESULT_VALID_BIT]    = result_valid_q;
    end

    assign bus.adc_start    = adc_start_q;
    assign bus.result_hi    = result_hi_q;
    assign bus.result_lo    = result_lo_q;
    assign bus.result_diff  = result_diff_q;
    assign bus.result_valid = result_valid_q;
    assign sample_count     = sample_count_q;
    assign err_overrun      = err_overrun_q;
    assign err_timeout      = err_timeout_q;
    assign err_short        = err_short_q;
    assign monitor          = monitor_s;

endmodule

// File: tb/tb_az_sample_capture.sv
// Randomized window/conversion stimulus for az_sample_capture, checked against a
// transaction-level model of holding registers, pending result and error flags.
module tb_az_sample_capture;

    localparam int TO_N = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_active;
    logic        sample_phase;
    logic [23:0] settle_n;
    logic [31:0] sample_count;
    logic        err_clr;
    logic        err_overrun, err_timeout, err_short;
    logic [7:0]  monitor;

    az_sample_capture_if bus_if ();

    az_sample_capture #(.TIMEOUT_N(TO_N)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_active (sample_active),
        .sample_phase  (sample_phase),
        .settle_n      (settle_n),
        .bus           (bus_if),
        .sample_count  (sample_count),
        .err_clr       (err_clr),
        .err_overrun   (err_overrun),
        .err_timeout   (err_timeout),
        .err_short     (err_short),
        .monitor       (monitor)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_have_hi;
    logic [23:0] m_hold_hi;
    logic [23:0] m_res_hi, m_res_lo;
    bit          m_pend;
    int unsigned m_cnt;
    bit          m_ovr, m_to, m_short;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_diff(input logic [23:0] h, input logic [23:0] l);
        int d;
        d = int'($signed(h)) - int'($signed(l));
        return 32'(d) & 32'h01FF_FFFF;
    endfunction

    task automatic model_reset();
        m_have_hi = 0; m_hold_hi = 24'd0; m_res_hi = 24'd0; m_res_lo = 24'd0;
        m_pend = 0; m_cnt = 0; m_ovr = 0; m_to = 0; m_short = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"},   sample_count, m_cnt);
        check({tag, "_overrun"}, {31'd0, err_overrun}, {31'd0, m_ovr});
        check({tag, "_timeout"}, {31'd0, err_timeout}, {31'd0, m_to});
        check({tag, "_short"},   {31'd0, err_short},   {31'd0, m_short});
    endtask

    task automatic check_result(input string tag);
        check({tag, "_valid"}, {31'd0, bus_if.result_valid}, {31'd0, m_pend});
        check({tag, "_hi"},    {8'd0, bus_if.result_hi}, {8'd0, m_res_hi});
        check({tag, "_lo"},    {8'd0, bus_if.result_lo}, {8'd0, m_res_lo});
        check({tag, "_diff"},  {7'd0, bus_if.result_diff}, exp_diff(m_res_hi, m_res_lo));
    endtask

    // One window: detect, settle, ADC answered dly clocks after adc_start.
    task automatic run_window(input logic ph, input logic [23:0] st, input int dly,
                              input logic [23:0] dat, input logic rdy);
        int lat;
        bit pair_new;
        bus_if.result_ready = rdy;
        if (rdy && m_pend) begin m_cnt++; m_pend = 0; end
        sample_phase  = ph;
        settle_n      = st;
        sample_active = 1'b1;
        lat = 0;
        for (int j = 1; (j <= int'(st) + 4) && (lat == 0); j++) begin
            @(negedge clk);
            if (bus_if.adc_start) lat = j;
        end
        check("adc_start_latency", 32'(lat), 32'(st) + 32'd1);
        if (lat == 0) begin
            sample_active = 1'b0;
            repeat (4) @(negedge clk);
            return;
        end
        @(negedge clk);
        check("adc_start_pulse", {31'd0, bus_if.adc_start}, 32'd0);
        repeat (dly - 1) @(negedge clk);
        bus_if.adc_valid = 1'b1;
        bus_if.adc_data  = dat;
        pair_new = 0;
        if (ph) begin
            m_hold_hi = dat;
            m_have_hi = 1;
        end else if (m_have_hi) begin
            m_have_hi = 0;
            if (m_pend) begin
                m_ovr = 1;
            end else begin
                pair_new = 1;
                m_res_hi = m_hold_hi;
                m_res_lo = dat;
            end
        end
        @(negedge clk);
        bus_if.adc_valid = 1'b0;
        bus_if.adc_data  = 24'($urandom());
        sample_active    = 1'b0;
        @(negedge clk);
        if (pair_new) check("valid_early", {31'd0, bus_if.result_valid}, 32'd0);
        @(negedge clk);
        if (pair_new) m_pend = 1;
        check_result("win");
        check("monitor", {24'd0, monitor}, 32'(m_pend) << 4);
        if (rdy && m_pend) begin m_cnt++; m_pend = 0; end
        repeat (3) @(negedge clk);
        check_state("win");
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovr = 0; m_to = 0; m_short = 0;
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int starts;
        int lat;
        reset = 1'b0; sample_active = 1'b0; sample_phase = 1'b0; settle_n = 24'd0;
        err_clr = 1'b0; bus_if.adc_valid = 1'b0; bus_if.adc_data = 24'd0;
        bus_if.result_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_adc_start", {31'd0, bus_if.adc_start}, 32'd0);
        check("reset_monitor", {24'd0, monitor}, 32'd0);
        check_result("reset");
        check_state("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reference pair: +0x100 minus -0x100
        run_window(1'b1, 24'd10, 5, 24'h000100, 1'b1);
        run_window(1'b0, 24'd10, 5, 24'hFFFF00, 1'b1);
        check("ref_diff", {7'd0, bus_if.result_diff}, 32'h200);
        check("ref_count", sample_count, 32'd1);

        // Overrun: first pair held while ready stays low, second pair dropped
        run_window(1'b1, 24'd4, 3, 24'h123456, 1'b0);
        run_window(1'b0, 24'd0, 2, 24'h654321, 1'b0);
        run_window(1'b1, 24'd2, 4, 24'h7FFFFF, 1'b0);
        run_window(1'b0, 24'd1, 1, 24'h800000, 1'b0);
        check("ovr_flag", {31'd0, err_overrun}, 32'd1);
        check("ovr_held_hi", {8'd0, bus_if.result_hi}, 32'h123456);
        check("ovr_count", sample_count, 32'd1);
        bus_if.result_ready = 1'b1;
        m_cnt++; m_pend = 0;
        repeat (2) @(negedge clk);
        check("ovr_release_count", sample_count, 32'd2);
        check_result("ovr_release");

        // Timeout: no adc_valid after adc_start
        pulse_clr();
        sample_phase = 1'b1; settle_n = 24'd3; sample_active = 1'b1;
        lat = 0;
        for (int j = 1; (j <= 10) && (lat == 0); j++) begin
            @(negedge clk);
            if (bus_if.adc_start) lat = j;
        end
        check("to_adc_start", 32'(lat), 32'd4);
        repeat (TO_N) @(negedge clk);
        check("to_not_yet", {31'd0, err_timeout}, 32'd0);
        @(negedge clk);
        m_to = 1;
        check("to_flag", {31'd0, err_timeout}, 32'd1);
        check("to_state", {29'd0, monitor[2:0]}, 32'd0);
        check_result("to");
        sample_active = 1'b0;
        repeat (3) @(negedge clk);

        // Short window: active drops during a long settle
        sample_phase = 1'b0; settle_n = 24'd100; sample_active = 1'b1;
        starts = 0;
        repeat (20) begin @(negedge clk); if (bus_if.adc_start) starts++; end
        sample_active = 1'b0;
        repeat (10) begin @(negedge clk); if (bus_if.adc_start) starts++; end
        m_short = 1;
        check("short_no_start", 32'(starts), 32'd0);
        check("short_state", {29'd0, monitor[2:0]}, 32'd0);
        check_state("short");

        pulse_clr();
        check_state("clr");

        // Short event coinciding with err_clr: the set wins
        settle_n = 24'd50; sample_active = 1'b1;
        repeat (5) @(negedge clk);
        sample_active = 1'b0; err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_short = 1;
        check("set_wins", {31'd0, err_short}, 32'd1);
        repeat (2) @(negedge clk);

        // Randomized windows with stray ADC strobes and occasional clears
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus_if.adc_valid = 1'b1;
                bus_if.adc_data  = 24'($urandom());
                @(negedge clk);
                bus_if.adc_valid = 1'b0;
                @(negedge clk);
            end
            if ($urandom_range(0, 7) == 0) pulse_clr();
            run_window(1'($urandom_range(0, 1)), 24'($urandom_range(0, 12)),
                       int'($urandom_range(1, 12)), 24'($urandom()),
                       1'($urandom_range(0, 9) < 7));
        end

        // Reset during WAIT_ADC, then a late adc_valid with the window still open
        bus_if.result_ready = 1'b0;
        sample_phase = 1'b1; settle_n = 24'd2; sample_active = 1'b1;
        lat = 0;
        for (int j = 1; (j <= 8) && (lat == 0); j++) begin
            @(negedge clk);
            if (bus_if.adc_start) lat = j;
        end
        check("rst_adc_start", 32'(lat), 32'd3);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        check_result("in_reset");
        check_state("in_reset");
        check("in_reset_monitor", {24'd0, monitor}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        bus_if.adc_valid = 1'b1;
        bus_if.adc_data  = 24'h0ABCDE;
        @(negedge clk);
        bus_if.adc_valid = 1'b0;
        starts = 0;
        repeat (6) begin @(negedge clk); if (bus_if.adc_start) starts++; end
        check("post_rst_no_start", 32'(starts), 32'd0);
        check("post_rst_monitor", {24'd0, monitor}, 32'd0);
        check_result("post_rst");
        check_state("post_rst");
        sample_active = 1'b0;
        repeat (3) @(negedge clk);

        // Two LO windows then a HI window: nothing to pair
        run_window(1'b0, 24'd3, 2, 24'h000010, 1'b1);
        run_window(1'b0, 24'd0, 3, 24'h000020, 1'b1);
        run_window(1'b1, 24'd5, 2, 24'h000030, 1'b1);
        check("lo_lo_hi_no_result", {31'd0, bus_if.result_valid}, 32'd0);
        check("lo_lo_hi_count", sample_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/az_sample_capture.md
AZ_SAMPLE_CAPTURE -- requirements
Module: az_sample_capture

Interface
REQ-001 Parameter CLK_FREQ, default 20000000, is the clock frequency in Hz and is used only for default counts.
REQ-002 Parameter TIMEOUT_N, default CLK_FREQ*1e-3 (1 ms), is the ADC conversion timeout in clocks.
REQ-003 Port clk  input  1  is the system clock; all logic is on posedge.
REQ-004 Port reset  input  1  is an asynchronous, active-low reset.
REQ-005 Port sample_active  input  1  is high for the duration of each modulation sample window.
REQ-006 Port sample_phase  input  1  marks the window type: 1 = HI (pc-out/signal), 0 = LO (azmux lo).
REQ-007 Port settle_n  input  24  is the delay in clocks from window start to ADC start.
REQ-008 Port adc_start  output  1  is a single-cycle conversion request.
REQ-009 Port adc_valid  input  1  is a single-cycle strobe marking adc_data as valid.
REQ-010 Port adc_data  input  24  is the signed two's-complement conversion result.
REQ-011 Port result_hi, result_lo  output  24 each  are the latched HI and LO conversions of the emitted pair.
REQ-012 Port result_diff  output  25  is the signed difference result_hi minus result_lo.
REQ-013 Port result_valid  output  1 and result_ready  input  1  form a valid/ready handshake on the result.
REQ-014 Port sample_count  output  32  counts accepted results.
REQ-015 Port err_clr  input  1  clears the sticky error flags.
REQ-016 Port err_overrun, err_timeout, err_short  output  1 each  are sticky error flags.
REQ-017 Port monitor  output  8  carries debug state: bits[2:0] = state, bit3 = adc_start, bit4 = result_valid, bits[7:5] = 0.

Function
REQ-018 The block SHALL detect a window start as sample_active high while its one-cycle-delayed copy is low, and SHALL capture sample_phase in that cycle.
REQ-019 The state machine SHALL have states IDLE, SETTLE, START, WAIT_ADC, STORE and PAIR.
- IDLE to SETTLE on window start, loading the down-counter with settle_n.
REQ-020 In SETTLE the counter SHALL decrement each clock, and the block SHALL move to START when the counter reaches 0.
- settle_n = 0 gives START on the cycle immediately after detection.
REQ-021 START SHALL assert adc_start for exactly one clock, load the timeout counter with TIMEOUT_N, and go to WAIT_ADC.
REQ-022 In WAIT_ADC, adc_valid SHALL register adc_data into the hi or lo holding register selected by the captured phase, set the matching have flag, and go to STORE.
REQ-023 STORE SHALL go to PAIR if the phase was LO and have_hi is set; otherwise it SHALL go to IDLE.
REQ-024 PAIR SHALL load result_hi and result_lo, compute result_diff with sign extension to 25 bits (no overflow possible), assert result_valid, clear both have flags, and go to IDLE.
- Latency: adc_valid in cycle N gives result_valid high from cycle N+3.
REQ-025 result_valid SHALL stay high and the result outputs SHALL stay stable until the cycle in which result_valid and result_ready are both high; that cycle SHALL clear result_valid and increment sample_count, which wraps from 2^32-1 to 0.
REQ-026 If PAIR is reached while result_valid is high and result_ready is low, the new pair SHALL be dropped, the outputs SHALL stay unchanged, and err_overrun SHALL be set.
REQ-027 If sample_active falls during SETTLE or START, the block SHALL abort to IDLE with no adc_start (or ignore the issued one), and SHALL set err_short.
REQ-028 If the timeout counter reaches 0 in WAIT_ADC, the block SHALL set err_timeout, go to IDLE, and store nothing.
REQ-029 adc_valid outside WAIT_ADC SHALL be ignored.
REQ-030 A window start outside IDLE SHALL be ignored.
REQ-031 A HI after a HI SHALL overwrite the hi holding register.
REQ-032 A LO without have_hi SHALL be stored but SHALL produce no result.
REQ-033 err_clr SHALL clear all err_* flags; a set event in the same cycle wins over the clear.

Reset
REQ-034 While reset is low, the block SHALL force state to IDLE, all counters and registers to 0, have flags to 0, and adc_start, result_valid, err_* and monitor to 0.
REQ-035 Asserting reset mid-conversion SHALL discard the pending sample.
- After release, a window already in progress SHALL NOT be treated as a start, because the delayed copy resets to 1.

Structure
REQ-036 State encodings, CLK_FREQ and the monitor bit assignments SHALL live in the shared dmm defines package.
REQ-037 The down-counter SHALL be one sub-module, down_counter, instantiated once for settle and once for timeout.

Verification
REQ-038 settle_n = 10, HI window with adc_valid 5 clocks after start and data 0x000100, then LO window with data 0xFFFF00, result_ready = 1 -> adc_start 11 clocks after window start, result_diff = +0x200, sample_count = 1.
REQ-039 Pair completes with result_ready held low, then a second pair completes -> first result held, err_overrun = 1, sample_count unchanged until ready.
REQ-040 adc_valid never arrives after adc_start -> err_timeout after TIMEOUT_N clocks, no result_valid.
REQ-041 settle_n = 100 with sample_active dropped after 20 clocks -> no adc_start, err_short = 1, state IDLE.
REQ-042 Two LO windows then one HI window -> no result_valid.
REQ-043 Reset asserted in WAIT_ADC, then adc_valid arrives -> no store, all outputs 0.
